// File: rtl/sd_pkg.sv
// Shared SD command-layer definitions: FSM encoding, frame constants and the CRC7 byte step.
package sd_pkg;

  typedef enum logic [2:0] {StIdle, StSend, StPoll, StTrail, StDone} sd_state_e;

  localparam logic [7:0]  SD_FILL_BYTE = 8'hFF;
  localparam int unsigned SD_CMD_LEN   = 6;
  localparam logic [6:0]  CRC7_POLY    = 7'h09;

  localparam logic [5:0] SD_CMD0   = 6'd0;
  localparam logic [5:0] SD_CMD8   = 6'd8;
  localparam logic [5:0] SD_CMD55  = 6'd55;
  localparam logic [5:0] SD_ACMD41 = 6'd41;

  // Advances the CRC7 over one byte, MSB first.
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] din);
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ din[i];
      c  = {c[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
    return c;
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Byte-serial CRC7 accumulator; clear has priority over enable.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] din_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = '0;
    end else if (en_i) begin
      crc_d = crc7_byte(crc_q, din_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_engine.sv
// SPI-mode SD command sequencer: sends a CRC7-protected command frame, polls for R1,
// clocks one trailing fill byte and reports R1 or a timeout. Owns chip select.
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter int unsigned NCR_MAX = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_start_i,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] cmd_arg_i,
  output logic        cmd_ready_o,
  output logic        resp_valid_o,
  output logic [7:0]  resp_r1_o,
  output logic        resp_timeout_o,
  output logic        cs_n_o,
  output logic        spi_execute_o,
  output logic [7:0]  spi_out_word_o,
  input  logic [7:0]  spi_in_word_i,
  input  logic        spi_finished_i,
  input  logic        spi_busy_i
);

  localparam logic [7:0] NcrMaxB  = 8'(NCR_MAX);
  localparam logic [2:0] LastByte = 3'(SD_CMD_LEN - 1);

  sd_state_e   state_q;
  logic [39:0] frame_q;
  logic [2:0]  byte_cnt_q;
  logic [7:0]  poll_cnt_q;
  logic        pending_q;
  logic        cmd_ready_q, resp_valid_q, resp_timeout_q, cs_n_q, spi_execute_q;
  logic [7:0]  resp_r1_q, spi_out_word_q;

  logic [6:0]  crc;
  logic        active, accept, launch, byte_done, crc_en;

  assign active    = (state_q == StSend) || (state_q == StPoll) || (state_q == StTrail);
  // A byte left in flight by a reset keeps spi_busy high; wait it out before accepting.
  assign accept    = (state_q == StIdle) && cmd_start_i && !spi_busy_i;
  assign launch    = active && !pending_q && !spi_busy_i;
  assign byte_done = pending_q && spi_finished_i;
  assign crc_en    = launch && (state_q == StSend) && (byte_cnt_q != LastByte);

  sd_crc7 u_crc7 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (accept),
    .en_i   (crc_en),
    .din_i  (frame_q[39:32]),
    .crc_o  (crc)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      frame_q        <= '0;
      byte_cnt_q     <= '0;
      poll_cnt_q     <= '0;
      pending_q      <= 1'b0;
      cmd_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_r1_q      <= SD_FILL_BYTE;
      resp_timeout_q <= 1'b0;
      cs_n_q         <= 1'b1;
      spi_execute_q  <= 1'b0;
      spi_out_word_q <= SD_FILL_BYTE;
    end else begin
      spi_execute_q <= 1'b0;
      resp_valid_q  <= 1'b0;

      if (launch) begin
        spi_execute_q <= 1'b1;
        pending_q     <= 1'b1;
        if (state_q == StSend && byte_cnt_q == LastByte) begin
          spi_out_word_q <= {crc, 1'b1};
        end else if (state_q == StSend) begin
          spi_out_word_q <= frame_q[39:32];
          frame_q        <= {frame_q[31:0], 8'h00};
        end else begin
          spi_out_word_q <= SD_FILL_BYTE;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            frame_q        <= {2'b01, cmd_index_i, cmd_arg_i};
            byte_cnt_q     <= '0;
            poll_cnt_q     <= '0;
            pending_q      <= 1'b0;
            resp_timeout_q <= 1'b0;
            resp_r1_q      <= SD_FILL_BYTE;
            cs_n_q         <= 1'b0;
            cmd_ready_q    <= 1'b0;
            state_q        <= StSend;
          end
        end
        StSend: begin
          if (byte_done) begin
            pending_q  <= 1'b0;
            byte_cnt_q <= byte_cnt_q + 3'd1;
            if (byte_cnt_q == LastByte) state_q <= StPoll;
          end
        end
        StPoll: begin
          if (byte_done) begin
            pending_q <= 1'b0;
            if (!spi_in_word_i[7]) begin
              resp_r1_q <= spi_in_word_i;
              state_q   <= StTrail;
            end else begin
              poll_cnt_q <= poll_cnt_q + 8'd1;
              if (poll_cnt_q + 8'd1 == NcrMaxB) begin
                resp_timeout_q <= 1'b1;
                resp_r1_q      <= SD_FILL_BYTE;
                state_q        <= StTrail;
              end
            end
          end
        end
        StTrail: begin
          if (byte_done) begin
            pending_q    <= 1'b0;
            cs_n_q       <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= StDone;
          end
        end
        StDone: begin
          cmd_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o    = cmd_ready_q;
  assign resp_valid_o   = resp_valid_q;
  assign resp_r1_o      = resp_r1_q;
  assign resp_timeout_o = resp_timeout_q;
  assign cs_n_o         = cs_n_q;
  assign spi_execute_o  = spi_execute_q;
  assign spi_out_word_o = spi_out_word_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Bench for sd_cmd_engine: SPI byte-engine model with scripted card replies, directed table,
// multi-cycle corner sequences and randomized commands against a reference model.
module tb_sd_cmd_engine;
  import sd_pkg::*;

  localparam int NCR = 8;

  logic        clk = 1'b0;
  logic        rst_n, cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        cmd_ready, resp_valid, resp_timeout, cs_n, spi_execute;
  logic [7:0]  resp_r1, spi_out_word;
  logic [7:0]  spi_in_word = 8'hFF;
  logic        spi_finished = 1'b0;
  logic        spi_busy = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sd_cmd_engine #(.NCR_MAX(NCR)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cmd_start_i    (cmd_start),
    .cmd_index_i    (cmd_index),
    .cmd_arg_i      (cmd_arg),
    .cmd_ready_o    (cmd_ready),
    .resp_valid_o   (resp_valid),
    .resp_r1_o      (resp_r1),
    .resp_timeout_o (resp_timeout),
    .cs_n_o         (cs_n),
    .spi_execute_o  (spi_execute),
    .spi_out_word_o (spi_out_word),
    .spi_in_word_i  (spi_in_word),
    .spi_finished_i (spi_finished),
    .spi_busy_i     (spi_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- SPI byte engine model (no reset, like the real one) ----------------
  int          cyc = 0, last_fin = -10, xfer_idx = 0, m_lat = 0;
  bit          m_stale = 0, prev_exec = 0;
  logic [7:0]  m_held = 8'hFF, m_reply = 8'hFF;
  logic [7:0]  wire_q[$];
  logic [7:0]  resp_script[16];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n && spi_busy) m_stale = 1;
      if (spi_execute) begin
        chk("exec_while_busy", {63'd0, spi_busy}, 64'd0);
        chk("exec_one_cycle", {63'd0, prev_exec}, 64'd0);
      end
      if (spi_busy && rst_n && !m_stale) chk("word_stable", {56'd0, spi_out_word}, {56'd0, m_held});
      prev_exec = spi_execute;
      if (spi_finished) spi_finished = 1'b0;
      if (spi_busy) begin
        if (m_lat == 0) begin
          spi_busy     = 1'b0;
          spi_finished = 1'b1;
          spi_in_word  = m_reply;
          last_fin     = cyc;
          m_stale      = 0;
        end else begin
          m_lat--;
        end
      end else if (spi_execute) begin
        spi_busy = 1'b1;
        m_held   = spi_out_word;
        wire_q.push_back(spi_out_word);
        m_reply  = (xfer_idx >= 6 && xfer_idx < 22) ? resp_script[xfer_idx-6] : 8'hFF;
        xfer_idx++;
        m_lat    = $urandom_range(0, 3);
      end
    end
  end

  // ---------------- Reference model ----------------
  // CRC7 as the remainder of msg*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'd0};
    for (int i = 46; i >= 7; i--) if (r[i]) r[i-:8] = r[i-:8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};
  endfunction

  task automatic ref_resp(input logic [11:0][7:0] s, output logic [7:0] r1, output logic to,
                          output int polls);
    r1 = 8'hFF; to = 1'b1; polls = NCR;
    for (int k = NCR - 1; k >= 0; k--) begin
      if (!s[k][7]) begin r1 = s[k]; to = 1'b0; polls = k + 1; end
    end
  endtask

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (cmd_ready && !spi_busy) begin ok = 1; break; end
      nstep();
    end
    chk({tag, "_idle_wait"}, {63'd0, ok}, 64'd1);
  endtask

  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg,
                           input logic [11:0][7:0] scr);
    wire_q.delete();
    xfer_idx = 0;
    for (int k = 0; k < 16; k++) resp_script[k] = (k < 12) ? scr[k] : 8'hFF;
    cmd_index = idx; cmd_arg = arg; cmd_start = 1'b1;
    nstep();
    cmd_start = 1'b0; cmd_index = 6'($urandom); cmd_arg = $urandom;
  endtask

  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [11:0][7:0] scr, input logic [47:0] frame,
                         input logic [7:0] r1, input logic to, input int xfers, input bit poke);
    bit got = 0, poked = 0;
    wait_idle(tag);
    start_cmd(idx, arg, scr);
    chk({tag, "_cs_fall"}, {63'd0, cs_n}, 64'd0);
    chk({tag, "_ready_low"}, {63'd0, cmd_ready}, 64'd0);
    nstep();
    chk({tag, "_first_exec"}, {63'd0, spi_execute}, 64'd1);
    for (int i = 0; i < 3000 && !got; i++) begin
      if (resp_valid) begin
        got = 1;
      end else if (poke && !poked && xfer_idx == 7) begin
        cmd_start = 1'b1; cmd_index = SD_CMD0; cmd_arg = '0; poked = 1;
        nstep();
        cmd_start = 1'b0;
      end else begin
        nstep();
      end
    end
    chk({tag, "_resp_valid"}, {63'd0, got}, 64'd1);
    if (got) begin
      chk({tag, "_r1"}, {56'd0, resp_r1}, {56'd0, r1});
      chk({tag, "_timeout"}, {63'd0, resp_timeout}, {63'd0, to});
      chk({tag, "_cs_high_valid"}, {63'd0, cs_n}, 64'd1);
      chk({tag, "_valid_lat"}, 64'(cyc - last_fin), 64'd1);
      nstep();
      chk({tag, "_valid_pulse"}, {63'd0, resp_valid}, 64'd0);
      chk({tag, "_ready_back"}, {63'd0, cmd_ready}, 64'd1);
    end
    chk({tag, "_xfers"}, 64'(wire_q.size()), 64'(xfers));
    for (int j = 0; j < wire_q.size() && j < xfers; j++) begin
      logic [7:0] e;
      e = (j < 6) ? frame[47-8*j -: 8] : 8'hFF;
      chk($sformatf("%s_byte%0d", tag, j), {56'd0, wire_q[j]}, {56'd0, e});
    end
  endtask

  typedef struct {
    string            name;
    logic [5:0]       idx;
    logic [31:0]      arg;
    logic [11:0][7:0] script;
    logic [47:0]      frame;
    logic [7:0]       r1;
    logic             to;
    int               xfers;
  } vec_t;

  vec_t tab[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tab[0] = '{"cmd0", SD_CMD0, 32'h0, '1, 48'h40_0000_0000_95, 8'h01, 1'b0, 8};
    tab[0].script[0] = 8'h01;
    tab[1] = '{"cmd8", SD_CMD8, 32'h1AA, '1, 48'h48_0000_01AA_87, 8'h01, 1'b0, 10};
    tab[1].script[2] = 8'h01;
    tab[2] = '{"cmd55_to", SD_CMD55, 32'h0, '1, 48'h77_0000_0000_65, 8'hFF, 1'b1, 15};
    tab[3] = '{"cmd55_last", SD_CMD55, 32'h0, '1, 48'h77_0000_0000_65, 8'h00, 1'b0, 15};
    tab[3].script[7] = 8'h00;
    tab[4] = '{"bit7", SD_CMD0, 32'h0, '1, 48'h40_0000_0000_95, 8'h7F, 1'b0, 10};
    tab[4].script[0] = 8'h80; tab[4].script[1] = 8'hC1; tab[4].script[2] = 8'h7F;

    rst_n = 1'b0; cmd_start = 1'b0; cmd_index = '0; cmd_arg = '0;
    repeat (3) nstep();
    chk("rst_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_r1", {56'd0, resp_r1}, 64'hFF);
    chk("rst_timeout", {63'd0, resp_timeout}, 64'd0);
    chk("rst_cs_n", {63'd0, cs_n}, 64'd1);
    chk("rst_exec", {63'd0, spi_execute}, 64'd0);
    chk("rst_word", {56'd0, spi_out_word}, 64'hFF);
    rst_n = 1'b1;
    nstep();

    for (int i = 0; i < 5; i++)
      run_cmd(tab[i].name, tab[i].idx, tab[i].arg, tab[i].script, tab[i].frame, tab[i].r1,
              tab[i].to, tab[i].xfers, 1'b0);

    // cmd_start during POLL must be ignored
    run_cmd("poke", tab[1].idx, tab[1].arg, tab[1].script, tab[1].frame, tab[1].r1, tab[1].to,
            tab[1].xfers, 1'b1);

    // Reset while byte 3 of the frame is in flight
    begin
      bit seen = 0;
      wait_idle("rst_mid");
      start_cmd(SD_CMD8, 32'h1AA, '1);
      for (int i = 0; i < 300; i++) begin
        if (xfer_idx == 4) begin seen = 1; break; end
        nstep();
      end
      chk("rst_mid_reach_byte3", {63'd0, seen}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_cs_n", {63'd0, cs_n}, 64'd1);
      chk("rst_mid_ready", {63'd0, cmd_ready}, 64'd1);
      chk("rst_mid_exec", {63'd0, spi_execute}, 64'd0);
      chk("rst_mid_word", {56'd0, spi_out_word}, 64'hFF);
      nstep();
      rst_n = 1'b1;
      run_cmd("after_rst", tab[0].idx, tab[0].arg, tab[0].script, tab[0].frame, tab[0].r1,
              tab[0].to, tab[0].xfers, 1'b0);
    end

    for (int n = 0; n < 12; n++) begin
      logic [5:0]       idx;
      logic [31:0]      arg;
      logic [11:0][7:0] s;
      logic [7:0]       r1;
      logic             to;
      int               polls;
      idx = (n == 0) ? SD_ACMD41 : 6'($urandom);
      arg = (n == 0) ? 32'h4000_0000 : $urandom;
      for (int k = 0; k < 12; k++) s[k] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
      ref_resp(s, r1, to, polls);
      run_cmd($sformatf("rand%0d", n), idx, arg, s, ref_frame(idx, arg), r1, to, 6 + polls + 1,
              1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_cmd_engine.md
# sd_cmd_engine

Command-layer sequencer between the SD host logic and `spi_controller`. It accepts a 6-bit command index and a 32-bit argument, builds the 6-byte SPI-mode command frame with CRC7, and pushes it byte by byte through the SPI byte engine. It then polls with 0xFF fill bytes for the R1 response, sends one trailing 0xFF, and returns R1 or a timeout flag. It owns chip select.

## Interface
- `NCR_MAX`, 8: maximum number of poll bytes before timeout (1..255).
- `clk`  in  1  system clock; the same clock that drives `spi_controller`.
- `rst_n`  in  1  asynchronous active-low reset.
- `cmd_start`  in  1  request; accepted only when `cmd_ready`=1.
- `cmd_index`  in  6  command number, 0..63; sampled on accept.
- `cmd_arg`  in  32  argument, MSB first on the wire; sampled on accept.
- `cmd_ready`  out  1  engine idle; reset value 1.
- `resp_valid`  out  1  one-cycle completion pulse; reset value 0.
- `resp_r1`  out  8  R1 byte, held until the next accept; reset value 8'hFF.
- `resp_timeout`  out  1  no R1 within `NCR_MAX` bytes; valid with `resp_valid`; reset value 0.
- `cs_n`  out  1  SD chip select, active low; reset value 1.
- `spi_execute`  out  1  byte launch pulse to `spi_controller`; reset value 0.
- `spi_out_word`  out  8  byte to transmit; reset value 8'hFF.
- `spi_in_word`  in  8  received byte; sampled when `spi_finished`=1.
- `spi_finished`  in  1  byte complete.
- `spi_busy`  in  1  byte engine active.

## Operation
- FSM states: IDLE, SEND, POLL, TRAIL, DONE.
- **IDLE**
  - `cmd_ready`=1 and `cs_n`=1.
  - On `cmd_start`: latch the 48-bit frame `{2'b01, cmd_index, cmd_arg, crc7, 1'b1}`, clear the CRC, byte_cnt=0, poll_cnt=0, assert `cs_n`=0, and go to SEND.
- **SEND**
  - Transmits frame bytes 0..5 in order.
  - CRC7 (poly x^7+x^3+1, init 0) is accumulated over bytes 0..4 as each byte is launched. Byte 5 = `{crc7, 1'b1}`.
  - Go to POLL after byte 5 finishes.
- **POLL**
  - Transmit 0xFF and capture `spi_in_word`.
  - If bit7 of the received byte is 0: `resp_r1` = that byte, go to TRAIL.
  - Otherwise increment poll_cnt. When poll_cnt reaches `NCR_MAX`: set `resp_timeout`=1, `resp_r1`=8'hFF, go to TRAIL.
- **TRAIL**
  - Transmit one 0xFF with `cs_n` still low.
  - When it finishes, go to DONE.
- **DONE**
  - For one cycle: `cs_n`=1, `resp_valid`=1, `cmd_ready`=0.
  - Then go to IDLE.
- **Byte launch rule**
  - Drive `spi_out_word`, then assert `spi_execute` for exactly one cycle, only when `spi_busy`=0 and no byte is outstanding.
  - Hold `spi_out_word` stable until `spi_finished`.
  - Never launch a new byte in the same cycle `spi_finished` is seen.
- `cmd_start` while `cmd_ready`=0 is ignored; no queuing.
- `resp_timeout` is cleared on the next accept.
- **Reset mid-operation**
  - All outputs return to their reset values immediately and the FSM goes to IDLE.
  - A byte already in flight in `spi_controller` (which has no reset) completes; its `spi_finished` is ignored while in IDLE.
  - A new command is accepted only once `spi_busy`=0.

## Timing
- Accept takes 1 cycle, from the `cmd_start` sample to `cs_n` falling.
- First `spi_execute` occurs 1 cycle after `cs_n` falls.
- Inter-byte gap is 1 cycle between `spi_finished` and the next `spi_execute`.
- Best-case total is 6 command bytes + 1 poll + 1 trail = 8 byte transfers. Worst case is 6 + `NCR_MAX` + 1.
- `resp_valid` rises the cycle after the TRAIL byte finishes, and `cs_n` rises in that same cycle.
- `spi_finished` is a single-cycle pulse and must not be missed. The FSM samples it every cycle in every non-IDLE state.

## Structure
- Shared package `sd_pkg`:
  - FSM state encoding.
  - `SD_FILL_BYTE`=8'hFF.
  - `SD_CMD_LEN`=6.
  - `CRC7_POLY`=7'h09.
  - CMD0/CMD8/CMD55/ACMD41 index constants.
- Sub-module `sd_crc7`: byte-serial CRC7 with `clr`, `en`, `din[7:0]` inputs and `crc[6:0]` output, computed combinationally over 8 bits per enable.

## Test plan
- CMD0, arg 0 → wire bytes 40 00 00 00 00 95. Model returns 0x01 on the first poll → `resp_r1`=0x01, `resp_timeout`=0, 8 transfers total.
- CMD8, arg 0x000001AA → bytes 48 00 00 01 AA 87. Model returns FF, FF, 0x01 → `resp_r1`=0x01 after 3 polls.
- CMD55, arg 0; model always returns 0xFF with `NCR_MAX`=8 → `resp_timeout`=1, `resp_r1`=0xFF, 6+8+1=15 transfers, `cs_n` high in the `resp_valid` cycle.
- `cmd_start` pulsed during POLL with a different index → ignored; the wire stream and `resp_r1` are unchanged.
- `rst_n` asserted during byte 3 of SEND → `cs_n`=1, `cmd_ready`=1, `spi_execute`=0 immediately. The stale `spi_finished` is ignored, and a subsequent CMD0 produces a correct frame.
- Byte-handshake check: `spi_execute` is never asserted while `spi_busy`=1, is always exactly 1 cycle wide, and `spi_out_word` is stable from launch to finish across all scenarios.
